mux_rr_stream: RTL and testbench
================================

MUX_RR_STREAM -- requirements
Module: mux_rr_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data word width in bits.
REQ-002 The block SHALL have parameter N, default 4, meaning number of input channels (N >= 1).
REQ-003 The block SHALL derive SEL_W = max(1, ceil(log2 N)) as a local constant, not a port-overridable parameter.
REQ-004 Clk  input  1  rising-edge clock; the single clock of the block.
REQ-005 Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-006 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  per-channel word-valid.
REQ-008 in_ready  output  N  per-channel accept strobe; at most one bit high per cycle.
REQ-009 out_data  output  WIDTH  registered selected word.
REQ-010 out_sel  output  SEL_W  registered index of the channel that supplied out_data.
REQ-011 out_valid  output  1  out_data/out_sel hold a word.
REQ-012 out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high.

Function
REQ-013 Load enable SHALL be ld = !out_valid | out_ready.
REQ-014 Grant g SHALL be the first index with in_valid high, searching ptr, ptr+1, ... modulo N.
REQ-015 in_ready[g] SHALL be high iff ld and any in_valid is high; all other in_ready bits low.
REQ-016 On a cycle with ld and a grant, the next edge SHALL load out_data = channel g word, out_sel = g, out_valid = 1, ptr = (g+1) mod N.
REQ-017 On a cycle with ld and no in_valid, the next edge SHALL clear out_valid; out_data, out_sel and ptr SHALL hold.
REQ-018 When out_valid & !out_ready, out_data, out_sel and out_valid SHALL hold unchanged and all in_ready SHALL be low.
REQ-019 Latency SHALL be one cycle, input acceptance to out_valid; sustained throughput one word per cycle under continuous out_ready.
REQ-020 Simultaneous drain and load (out_valid, out_ready, a grant) SHALL replace the word with no bubble.
REQ-021 ptr SHALL wrap from N-1 to 0; with N=1 ptr is constant 0 and the block is a one-entry register slice.
REQ-022 in_ready MAY depend combinationally on in_valid and out_ready; no other combinational input-to-output path SHALL exist.

Reset
REQ-023 On Reset, out_valid = 0, out_data = 0, out_sel = 0 and ptr = 0 at the next edge; Reset overrides any simultaneous load.
REQ-024 in_ready SHALL be all-zero in any cycle with Reset high.
REQ-025 A word held mid-stall SHALL be discarded by Reset; it SHALL NOT reappear afterwards.

Configuration
REQ-026 Macro MUX_RR_FORCE_SEL_EN SHALL, when defined, add inputs force_en (1) and force_sel (SEL_W).
REQ-027 With the macro defined and force_en high, grant SHALL be force_sel if in_valid[force_sel] is high, otherwise no grant; ptr SHALL NOT change on forced grants.
REQ-028 Without the macro, the ports SHALL be absent and arbitration is pure round-robin per REQ-014.

Structure
REQ-029 Package mux_pkg SHALL hold the clog2 helper function and default WIDTH/N constants.
REQ-030 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req[N], ptr; outputs gnt index and any-grant).
REQ-031 All state (ptr, output register) SHALL reside in mux_rr_stream.

Verification
REQ-032 Reset held 2 cycles with all in_valid high -> in_ready = 0, out_valid = 0, out_data = 0, out_sel = 0.
REQ-033 N=4, all in_valid high, out_ready = 1, channel i data = 0x1000_000i -> out_sel sequence 0,1,2,3,0 on consecutive cycles, no bubbles.
REQ-034 Only channel 2 valid (data 0xDEADBEEF), out_ready = 0 for 3 cycles -> out_data = 0xDEADBEEF, out_sel = 2 stable, in_ready = 0 during stall; drained in the cycle out_ready rises.
REQ-035 ptr = 3, valids on channels 1 and 3 -> grant 3, then grant 1 (wrap check).
REQ-036 Reset asserted while out_valid = 1 and out_ready = 0 -> out_valid = 0 next cycle, word never delivered.
REQ-037 With MUX_RR_FORCE_SEL_EN, force_en = 1, force_sel = 1, all valid -> out_sel = 1 every cycle; after force_en drops, round-robin resumes from the unchanged ptr.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and elaboration-time helpers for the round-robin stream mux.
package mux_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_N     = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // A single channel still needs a one-bit select field.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first asserted request at or after ptr, modulo N.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N     = DEFAULT_N,
    localparam int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt,
    output logic             any_gnt
);

    localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

    always_comb begin
        logic [SEL_W:0]   sum;
        logic [SEL_W-1:0] idx;
        sum     = '0;
        idx     = '0;
        gnt     = '0;
        any_gnt = 1'b0;
        for (int i = 0; i < N; i++) begin
            // ptr < N and i < N, so a single conditional subtract is a full modulo.
            sum = {1'b0, ptr} + (SEL_W + 1)'(i);
            if (sum >= N_EXT) begin
                sum = sum - N_EXT;
            end
            idx = sum[SEL_W-1:0];
            if (!any_gnt && req[idx]) begin
                gnt     = idx;
                any_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_stream.sv
// N-to-1 round-robin stream mux with a single registered output slice.
// Optional MUX_RR_FORCE_SEL_EN adds force_en/force_sel to pin the grant to one channel.
module mux_rr_stream
    import mux_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int N     = DEFAULT_N,
    localparam int SEL_W = sel_width(N)
) (
    input  logic               Clk,
    input  logic               Reset,
`ifdef MUX_RR_FORCE_SEL_EN
    input  logic               force_en,
    input  logic [SEL_W-1:0]   force_sel,
`endif
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             vld_q, vld_d;

    logic             ld;
    logic [SEL_W-1:0] rr_gnt, gnt;
    logic             rr_any, gnt_vld, adv_ptr;

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] g);
        if (int'(g) >= N - 1) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

    rr_arbiter #(.N(N)) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (rr_gnt),
        .any_gnt (rr_any)
    );

    assign ld = !vld_q || out_ready;

    always_comb begin
        gnt     = rr_gnt;
        gnt_vld = rr_any;
        adv_ptr = 1'b1;
`ifdef MUX_RR_FORCE_SEL_EN
        // Forced grants leave the rotation untouched so round-robin resumes where it stopped.
        if (force_en) begin
            gnt     = force_sel;
            gnt_vld = (int'(force_sel) < N) && in_valid[force_sel];
            adv_ptr = 1'b0;
        end
`endif
    end

    always_comb begin
        in_ready = '0;
        if (!Reset && ld && gnt_vld) begin
            in_ready[gnt] = 1'b1;
        end
    end

    always_comb begin
        data_d = data_q;
        sel_d  = sel_q;
        vld_d  = vld_q;
        ptr_d  = ptr_q;
        if (ld) begin
            if (gnt_vld) begin
                data_d = in_data[int'(gnt)*WIDTH +: WIDTH];
                sel_d  = gnt;
                vld_d  = 1'b1;
                if (adv_ptr) begin
                    ptr_d = wrap_inc(gnt);
                end
            end else begin
                vld_d = 1'b0;
            end
        end
    end

    // Output register stage; reset clears the held word so a stalled beat is dropped.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            data_q <= '0;
            sel_q  <= '0;
            vld_q  <= 1'b0;
            ptr_q  <= '0;
        end else begin
            data_q <= data_d;
            sel_q  <= sel_d;
            vld_q  <= vld_d;
            ptr_q  <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Directed bench for mux_rr_stream with a cycle-level reference model and literal spot checks.
module tb_mux_rr_stream;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int SEL_W = 2;

    logic               Clk;
    logic               Reset;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_valid;
    logic               out_ready;
    logic               force_en;
    logic [SEL_W-1:0]   force_sel;
    logic [WIDTH-1:0]   ch_data [N];

    int n_checks = 0;
    int n_fail   = 0;

    mux_rr_stream #(.WIDTH(WIDTH), .N(N)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
`ifdef MUX_RR_FORCE_SEL_EN
        .force_en  (force_en),
        .force_sel (force_sel),
`endif
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always_comb begin
        in_data = '0;
        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = ch_data[i];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: holds the output word, valid flag and rotation pointer as plain values.
    int               m_ptr = 0, n_ptr = 0;
    logic             m_vld = 1'b0, n_vld = 1'b0;
    logic [WIDTH-1:0] m_data = '0, n_data = '0;
    int               m_sel = 0, n_sel = 0;
    logic             m_known = 1'b0, n_known = 1'b0;

    always @(negedge Clk) begin
        int           g;
        logic         gv, ld, forced;
        logic [N-1:0] exp_rdy;
        g = 0; gv = 1'b0; forced = 1'b0;
        ld = !m_vld || out_ready;
`ifdef MUX_RR_FORCE_SEL_EN
        if (force_en) begin
            forced = 1'b1;
            if (in_valid[force_sel]) begin g = int'(force_sel); gv = 1'b1; end
        end
`endif
        if (!forced) begin
            for (int i = 0; i < N; i++) begin
                if (!gv && in_valid[(m_ptr + i) % N]) begin g = (m_ptr + i) % N; gv = 1'b1; end
            end
        end
        exp_rdy = '0;
        if (!Reset && ld && gv) exp_rdy[g] = 1'b1;
        check("model_in_ready", 64'(in_ready), 64'(exp_rdy));
        if (m_known) begin
            check("model_out_valid", 64'(out_valid), 64'(m_vld));
            if (m_vld) begin
                check("model_out_data", 64'(out_data), 64'(m_data));
                check("model_out_sel", 64'(out_sel), 64'(m_sel));
            end
        end
        n_vld = m_vld; n_data = m_data; n_sel = m_sel; n_ptr = m_ptr; n_known = m_known;
        if (Reset) begin
            n_vld = 1'b0; n_data = '0; n_sel = 0; n_ptr = 0; n_known = 1'b1;
        end else if (ld) begin
            if (gv) begin
                n_vld = 1'b1; n_data = ch_data[g]; n_sel = g;
                if (!forced) n_ptr = (g + 1) % N;
            end else begin
                n_vld = 1'b0;
            end
        end
    end

    always @(posedge Clk) begin
        m_vld <= n_vld; m_data <= n_data; m_sel <= n_sel; m_ptr <= n_ptr; m_known <= n_known;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_counting_data();
        for (int i = 0; i < N; i++) ch_data[i] = 32'h1000_0000 + 32'(i);
    endtask

    initial begin
        Reset = 1'b1; in_valid = '1; out_ready = 1'b1; force_en = 1'b0; force_sel = '0;
        set_counting_data();

        // Reset with every channel requesting.
        @(negedge Clk);
        check("rst_in_ready", 64'(in_ready), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        check("rst_out_sel", 64'(out_sel), 64'h0);
        tick();
        @(negedge Clk);
        check("rst_in_ready_2", 64'(in_ready), 64'h0);
        tick();
        Reset = 1'b0;
        @(negedge Clk);
        check("rr_first_ready", 64'(in_ready), 64'h1);
        check("rr_idle_valid", 64'(out_valid), 64'h0);

        // Full rotation with no bubbles: 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 4) begin
                in_valid = 4'b0100; ch_data[2] = 32'hDEAD_BEEF;
            end
            @(negedge Clk);
            check("rr_seq_valid", 64'(out_valid), 64'h1);
            check("rr_seq_sel", 64'(out_sel), 64'(k % 4));
            check("rr_seq_data", 64'(out_data), 64'h1000_0000 + 64'(k % 4));
        end
        check("ch2_ready", 64'(in_ready), 64'h4);

        // Stall with only channel 2 valid.
        tick();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) tick();
            @(negedge Clk);
            check("stall_data", 64'(out_data), 64'hDEAD_BEEF);
            check("stall_sel", 64'(out_sel), 64'h2);
            check("stall_in_ready", 64'(in_ready), 64'h0);
        end
        tick();
        out_ready = 1'b1; in_valid = '0;
        @(negedge Clk);
        check("stall_still_valid", 64'(out_valid), 64'h1);

        // Drain, then wrap check from ptr=3 with channels 1 and 3.
        tick();
        in_valid = 4'b1010; ch_data[1] = 32'h1111_1111; ch_data[3] = 32'h3333_3333;
        @(negedge Clk);
        check("drained", 64'(out_valid), 64'h0);
        check("wrap_ready3", 64'(in_ready), 64'h8);
        tick();
        @(negedge Clk);
        check("wrap_sel3", 64'(out_sel), 64'h3);
        check("wrap_ready1", 64'(in_ready), 64'h2);
        tick();
        in_valid = 4'b0001; ch_data[0] = 32'hAAAA_5555;
        @(negedge Clk);
        check("wrap_sel1", 64'(out_sel), 64'h1);
        check("wrap_data1", 64'(out_data), 64'h1111_1111);

        // Reset while a word is stalled: it must never be delivered.
        tick();
        out_ready = 1'b0; in_valid = '0;
        @(negedge Clk);
        check("held_data", 64'(out_data), 64'hAAAA_5555);
        tick();
        Reset = 1'b1; in_valid = '1; out_ready = 1'b1;
        @(negedge Clk);
        check("rst_override_ready", 64'(in_ready), 64'h0);
        tick();
        Reset = 1'b0; in_valid = '0;
        @(negedge Clk);
        check("rst_drop_valid", 64'(out_valid), 64'h0);
        check("rst_drop_data", 64'(out_data), 64'h0);
        repeat (3) begin
            tick();
            @(negedge Clk);
            check("no_reappear", 64'(out_valid), 64'h0);
        end

        // Pointer restarts at 0 after reset.
        tick();
        in_valid = '1; set_counting_data();
        @(negedge Clk);
        check("post_rst_ready", 64'(in_ready), 64'h1);
        tick();
        @(negedge Clk);
        check("post_rst_sel", 64'(out_sel), 64'h0);

`ifdef MUX_RR_FORCE_SEL_EN
        // Forced channel 1, then round-robin resumes from ptr=2.
        tick();
        force_en = 1'b1; force_sel = 2'd1;
        @(negedge Clk);
        check("force_ready", 64'(in_ready), 64'h2);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 2) force_en = 1'b0;
            @(negedge Clk);
            check("force_sel", 64'(out_sel), 64'h1);
        end
        check("resume_ready", 64'(in_ready), 64'h4);
        tick();
        @(negedge Clk);
        check("resume_sel", 64'(out_sel), 64'h2);
`endif

        tick();
        in_valid = '0;
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
